// File: rtl/run_sequencer_if.sv
// run_sequencer_if
//   Bundles the host command channel and the spi_master state-control
//   signals seen by run_sequencer.
//   master : the sequencer's view (drives cmd_ready, ctl_start/stop, status flags)
//   slave  : the host / spi_master view (drives command, abort, ctl_status/clear)
//   Signals:
//     cmd_valid, cmd_ready, cmd_count[CNT_W], cmd_hold[HOLD_W], abort  - host command
//     ctl_start, ctl_stop, ctl_status, ctl_clear                        - spi_master control
//     busy, done, err, err_code[2], runs_done[CNT_W]                    - host status
interface run_sequencer_if #(
  parameter int CNT_W  = 8,
  parameter int HOLD_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [CNT_W-1:0]  cmd_count;
  logic [HOLD_W-1:0] cmd_hold;
  logic              abort;
  logic              ctl_start;
  logic              ctl_stop;
  logic              ctl_status;
  logic              ctl_clear;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        err_code;
  logic [CNT_W-1:0]  runs_done;

  modport master (
    input  cmd_valid, cmd_count, cmd_hold, abort, ctl_status, ctl_clear,
    output cmd_ready, ctl_start, ctl_stop, busy, done, err, err_code, runs_done
  );

  modport slave (
    output cmd_valid, cmd_count, cmd_hold, abort, ctl_status, ctl_clear,
    input  cmd_ready, ctl_start, ctl_stop, busy, done, err, err_code, runs_done
  );
endinterface

// File: rtl/run_sequencer.sv
// run_sequencer
//   Upstream controller for the spi_master state-control bus. Accepts a burst
//   command (run count, hold cycles) and, for each run, pulses ctl_start, waits
//   for ctl_status, holds, pulses ctl_stop and waits for a rising ctl_clear.
//   Reports completion (done), termination (err + err_code) and runs_done.
//   Ports:
//     clk  - system clock
//     rst  - synchronous reset, active-high
//     bus  - run_sequencer_if.master (command, control and status signals)
//   err_code: 0 none, 1 ack timeout, 2 clear timeout, 3 abort.
module run_sequencer #(
  parameter int CNT_W  = 8,
  parameter int HOLD_W = 8,
  parameter int TMO    = 64
) (
  input  logic               clk,
  input  logic               rst,
  run_sequencer_if.master    bus
);

  // Timer must cover both the timeout and the longest hold count.
  localparam int MAXV = (TMO > (1 << HOLD_W)) ? TMO : (1 << HOLD_W);
  localparam int TW   = $clog2(MAXV) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT_ACK, S_HOLD, S_STOP, S_WAIT_CLR, S_DONE, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [CNT_W-1:0]  runs_done_q, runs_done_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              clr_q, clr_d;

  logic              accept;
  logic              clr_ev;
  logic              abort_act;
  logic [CNT_W-1:0]  runs_inc;

  assign accept   = bus.cmd_valid && (state_q == S_IDLE);
  // start_clear may stay high for several cycles; only its rising edge counts.
  assign clr_ev   = bus.ctl_clear && !clr_q;
  assign runs_inc = runs_done_q + CNT_W'(1);
  assign clr_d    = bus.ctl_clear;

  // Abort only cancels an active burst; IDLE/DONE/ERR already head to IDLE.
  always_comb begin
    abort_act = 1'b0;
    case (state_q)
      S_START, S_WAIT_ACK, S_HOLD, S_STOP, S_WAIT_CLR: abort_act = bus.abort;
      default:                                         abort_act = 1'b0;
    endcase
  end

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      runs_done_q <= '0;
      err_code_q  <= 2'd0;
      clr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      runs_done_q <= runs_done_d;
      err_code_q  <= err_code_d;
      clr_q       <= clr_d;
    end
  end

  // Command parameters are plain data latched at accept; no reset needed.
  always_ff @(posedge clk) begin
    count_q <= count_d;
    hold_q  <= hold_d;
  end

  // ---- next-state logic ----
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    runs_done_d = runs_done_q;
    err_code_d  = err_code_q;
    count_d     = count_q;
    hold_d      = hold_q;

    if (abort_act) begin
      state_d    = S_ERR;
      err_code_d = 2'd3;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            count_d     = bus.cmd_count;
            hold_d      = bus.cmd_hold;
            runs_done_d = '0;
            err_code_d  = 2'd0;
            state_d     = (bus.cmd_count != '0) ? S_START : S_DONE;
          end
        end
        S_START: begin
          state_d = S_WAIT_ACK;
          timer_d = '0;
        end
        S_WAIT_ACK: begin
          // A status arriving on the timeout cycle still wins.
          if (bus.ctl_status) begin
            state_d = S_HOLD;
            timer_d = '0;
          end else if (timer_q == TW'(TMO - 1)) begin
            state_d    = S_ERR;
            err_code_d = 2'd1;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        S_HOLD: begin
          if (timer_q == TW'(hold_q)) state_d = S_STOP;
          else                         timer_d = timer_q + TW'(1);
        end
        S_STOP: begin
          state_d = S_WAIT_CLR;
          timer_d = '0;
        end
        S_WAIT_CLR: begin
          if (clr_ev) begin
            runs_done_d = runs_inc;
            state_d     = (runs_inc == count_q) ? S_DONE : S_START;
          end else if (timer_q == TW'(TMO - 1)) begin
            state_d    = S_ERR;
            err_code_d = 2'd2;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        S_ERR:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---- outputs (Moore, decoded from registered state) ----
  always_comb begin
    bus.cmd_ready = (state_q == S_IDLE);
    bus.busy      = (state_q != S_IDLE);
    bus.ctl_start = (state_q == S_START);
    // ERR also stops so spi_master never stays started after a failed burst.
    bus.ctl_stop  = (state_q == S_STOP) || (state_q == S_ERR);
    bus.done      = (state_q == S_DONE);
    bus.err       = (state_q == S_ERR);
    bus.err_code  = err_code_q;
    bus.runs_done = runs_done_q;
  end

endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer
//   Directed bench for run_sequencer with a small spi_master response model
//   (status rises after a start pulse, clear held high 3 cycles after a stop).
module tb_run_sequencer;
  localparam int CNT_W  = 8;
  localparam int HOLD_W = 8;
  localparam int TMO    = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic model_en   = 1'b0;
  logic man_status = 1'b0;
  logic man_clear  = 1'b0;
  logic m_status;
  int   clr_left;

  run_sequencer_if #(.CNT_W(CNT_W), .HOLD_W(HOLD_W)) ifc ();

  run_sequencer #(.CNT_W(CNT_W), .HOLD_W(HOLD_W), .TMO(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  assign ifc.ctl_status = model_en ? m_status : man_status;
  assign ifc.ctl_clear  = model_en ? (clr_left != 0) : man_clear;

  // spi_master response model
  always @(posedge clk) begin
    if (!model_en) begin
      m_status <= 1'b0;
      clr_left <= 0;
    end else begin
      if (ifc.ctl_start) m_status <= 1'b1;
      if (ifc.ctl_stop) begin
        m_status <= 1'b0;
        clr_left <= 3;
      end else if (clr_left != 0) begin
        clr_left <= clr_left - 1;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic accept_cmd(input int cnt, input int hold);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_count = CNT_W'(cnt);
    ifc.cmd_hold  = HOLD_W'(hold);
    tick();
    ifc.cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (ifc.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cmd_ready: got %0b want 1", ifc.cmd_ready); end
    n_cmp++; if (ifc.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b want 0", ifc.busy); end
    n_cmp++; if (ifc.ctl_start !== 1'b0) begin n_bad++; $display("FAIL reset_ctl_start: got %0b want 0", ifc.ctl_start); end
    n_cmp++; if (ifc.ctl_stop !== 1'b0) begin n_bad++; $display("FAIL reset_ctl_stop: got %0b want 0", ifc.ctl_stop); end
    n_cmp++; if (ifc.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %0b want 0", ifc.done); end
    n_cmp++; if (ifc.err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %0b want 0", ifc.err); end
    n_cmp++; if (ifc.err_code !== 2'd0) begin n_bad++; $display("FAIL reset_err_code: got %0d want 0", ifc.err_code); end
    n_cmp++; if (ifc.runs_done !== 8'd0) begin n_bad++; $display("FAIL reset_runs_done: got %0d want 0", ifc.runs_done); end
    rst = 1'b0;
    tick();
    n_cmp++; if (ifc.busy !== 1'b0) begin n_bad++; $display("FAIL post_reset_busy: got %0b want 0", ifc.busy); end
  endtask

  task automatic test_burst;
    int starts = 0, stops = 0, dones = 0, errs = 0, t_start = -1, t_stop = -1;
    bit fin = 1'b0;
    model_en = 1'b1;
    tick();
    accept_cmd(3, 2);
    for (int i = 0; i < 300; i++) begin
      if (ifc.ctl_start) begin starts++; if (t_start < 0) t_start = i; end
      if (ifc.ctl_stop) begin stops++; if (t_stop < 0) t_stop = i; end
      if (ifc.done) dones++;
      if (ifc.err) errs++;
      if (!ifc.busy) begin fin = 1'b1; break; end
      tick();
    end
    n_cmp++; if (fin !== 1'b1) begin n_bad++; $display("FAIL burst_finish: got %0b want 1 (timeout)", fin); end
    n_cmp++; if (starts != 3) begin n_bad++; $display("FAIL burst_starts: got %0d want 3", starts); end
    n_cmp++; if (stops != 3) begin n_bad++; $display("FAIL burst_stops: got %0d want 3", stops); end
    n_cmp++; if (dones != 1) begin n_bad++; $display("FAIL burst_done: got %0d want 1", dones); end
    n_cmp++; if (errs != 0) begin n_bad++; $display("FAIL burst_err: got %0d want 0", errs); end
    n_cmp++; if (ifc.runs_done !== 8'd3) begin n_bad++; $display("FAIL burst_runs_done: got %0d want 3", ifc.runs_done); end
    n_cmp++; if (ifc.err_code !== 2'd0) begin n_bad++; $display("FAIL burst_err_code: got %0d want 0", ifc.err_code); end
    n_cmp++; if (t_stop - t_start != 5) begin n_bad++; $display("FAIL burst_start_to_stop: got %0d want 5", t_stop - t_start); end
  endtask

  task automatic test_zero_count;
    model_en  = 1'b0;
    ifc.abort = 1'b1;
    accept_cmd(0, 5);
    ifc.abort = 1'b0;
    n_cmp++; if (ifc.done !== 1'b1) begin n_bad++; $display("FAIL zero_done: got %0b want 1", ifc.done); end
    n_cmp++; if (ifc.err !== 1'b0) begin n_bad++; $display("FAIL zero_err: got %0b want 0", ifc.err); end
    n_cmp++; if (ifc.ctl_start !== 1'b0) begin n_bad++; $display("FAIL zero_ctl_start: got %0b want 0", ifc.ctl_start); end
    n_cmp++; if (ifc.runs_done !== 8'd0) begin n_bad++; $display("FAIL zero_runs_done: got %0d want 0", ifc.runs_done); end
    tick();
    n_cmp++; if (ifc.busy !== 1'b0) begin n_bad++; $display("FAIL zero_busy_after: got %0b want 0", ifc.busy); end
    n_cmp++; if (ifc.done !== 1'b0) begin n_bad++; $display("FAIL zero_done_after: got %0b want 0", ifc.done); end
  endtask

  task automatic test_ack_timeout;
    bit early = 1'b0;
    model_en   = 1'b0;
    man_status = 1'b0;
    accept_cmd(1, 0);
    n_cmp++; if (ifc.ctl_start !== 1'b1) begin n_bad++; $display("FAIL ack_tmo_start: got %0b want 1", ifc.ctl_start); end
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (ifc.err) early = 1'b1;
    end
    n_cmp++; if (early !== 1'b0) begin n_bad++; $display("FAIL ack_tmo_early_err: got %0b want 0", early); end
    tick();
    n_cmp++; if (ifc.err !== 1'b1) begin n_bad++; $display("FAIL ack_tmo_err_c65: got %0b want 1", ifc.err); end
    n_cmp++; if (ifc.ctl_stop !== 1'b1) begin n_bad++; $display("FAIL ack_tmo_stop: got %0b want 1", ifc.ctl_stop); end
    n_cmp++; if (ifc.err_code !== 2'd1) begin n_bad++; $display("FAIL ack_tmo_code: got %0d want 1", ifc.err_code); end
    tick();
    n_cmp++; if (ifc.busy !== 1'b0) begin n_bad++; $display("FAIL ack_tmo_idle: got %0b want 0", ifc.busy); end
    n_cmp++; if (ifc.err_code !== 2'd1) begin n_bad++; $display("FAIL ack_tmo_code_held: got %0d want 1", ifc.err_code); end
  endtask

  task automatic test_clear_once;
    bit early = 1'b0;
    model_en   = 1'b0;
    man_status = 1'b0;
    man_clear  = 1'b0;
    accept_cmd(2, 0);          // c0 START
    man_status = 1'b1;
    tick(); tick(); tick();    // c3 STOP
    n_cmp++; if (ifc.ctl_stop !== 1'b1) begin n_bad++; $display("FAIL clr_stop_c3: got %0b want 1", ifc.ctl_stop); end
    tick();                    // c4 WAIT_CLR
    man_clear = 1'b1;          // high for c4..c8
    tick();                    // c5 START of run 2
    n_cmp++; if (ifc.ctl_start !== 1'b1) begin n_bad++; $display("FAIL clr_restart_c5: got %0b want 1", ifc.ctl_start); end
    n_cmp++; if (ifc.runs_done !== 8'd1) begin n_bad++; $display("FAIL clr_runs_c5: got %0d want 1", ifc.runs_done); end
    tick(); tick(); tick();    // c8 STOP
    n_cmp++; if (ifc.ctl_stop !== 1'b1) begin n_bad++; $display("FAIL clr_stop_c8: got %0b want 1", ifc.ctl_stop); end
    tick();                    // c9 WAIT_CLR
    man_clear = 1'b0;
    n_cmp++; if (ifc.runs_done !== 8'd1) begin n_bad++; $display("FAIL clr_counted_once: got %0d want 1", ifc.runs_done); end
    for (int i = 0; i < 63; i++) begin
      tick();
      if (ifc.err) early = 1'b1;
    end
    n_cmp++; if (early !== 1'b0) begin n_bad++; $display("FAIL clr_tmo_early_err: got %0b want 0", early); end
    tick();                    // c73 ERR
    n_cmp++; if (ifc.err !== 1'b1) begin n_bad++; $display("FAIL clr_tmo_err: got %0b want 1", ifc.err); end
    n_cmp++; if (ifc.err_code !== 2'd2) begin n_bad++; $display("FAIL clr_tmo_code: got %0d want 2", ifc.err_code); end
    n_cmp++; if (ifc.runs_done !== 8'd1) begin n_bad++; $display("FAIL clr_tmo_runs: got %0d want 1", ifc.runs_done); end
    man_status = 1'b0;
    tick();
  endtask

  task automatic test_abort;
    int s = 0;
    bit got = 1'b0;
    model_en = 1'b1;
    tick();
    accept_cmd(4, 2);
    for (int i = 0; i < 60; i++) begin
      if (ifc.ctl_start) s++;
      if (s == 2) begin got = 1'b1; break; end
      tick();
    end
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL abort_second_start: got %0b want 1 (timeout)", got); end
    tick(); tick();            // first HOLD cycle of run 2
    ifc.abort = 1'b1;
    tick();
    ifc.abort = 1'b0;
    n_cmp++; if (ifc.err !== 1'b1) begin n_bad++; $display("FAIL abort_err: got %0b want 1", ifc.err); end
    n_cmp++; if (ifc.ctl_stop !== 1'b1) begin n_bad++; $display("FAIL abort_stop: got %0b want 1", ifc.ctl_stop); end
    n_cmp++; if (ifc.err_code !== 2'd3) begin n_bad++; $display("FAIL abort_code: got %0d want 3", ifc.err_code); end
    n_cmp++; if (ifc.runs_done !== 8'd1) begin n_bad++; $display("FAIL abort_runs: got %0d want 1", ifc.runs_done); end
    n_cmp++; if (ifc.done !== 1'b0) begin n_bad++; $display("FAIL abort_done: got %0b want 0", ifc.done); end
    tick();
    n_cmp++; if (ifc.busy !== 1'b0) begin n_bad++; $display("FAIL abort_idle: got %0b want 0", ifc.busy); end
    n_cmp++; if (ifc.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready: got %0b want 1", ifc.cmd_ready); end
  endtask

  task automatic test_rst_mid;
    int starts = 0, stops = 0, dones = 0, errs = 0, t_start = -1, t_stop = -1;
    bit got = 1'b0, fin = 1'b0;
    model_en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    accept_cmd(2, 1);
    for (int i = 0; i < 60; i++) begin
      if (ifc.ctl_stop) begin got = 1'b1; break; end
      tick();
    end
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL rst_mid_stop_seen: got %0b want 1 (timeout)", got); end
    tick();                    // WAIT_CLR
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (ifc.busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy: got %0b want 0", ifc.busy); end
    n_cmp++; if (ifc.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_ready: got %0b want 1", ifc.cmd_ready); end
    n_cmp++; if (ifc.err_code !== 2'd0) begin n_bad++; $display("FAIL rst_mid_code: got %0d want 0", ifc.err_code); end
    n_cmp++; if (ifc.runs_done !== 8'd0) begin n_bad++; $display("FAIL rst_mid_runs: got %0d want 0", ifc.runs_done); end
    n_cmp++; if (ifc.ctl_stop !== 1'b0) begin n_bad++; $display("FAIL rst_mid_stop: got %0b want 0", ifc.ctl_stop); end
    for (int i = 0; i < 5; i++) tick();
    accept_cmd(1, 0);
    for (int i = 0; i < 100; i++) begin
      if (ifc.ctl_start) begin starts++; if (t_start < 0) t_start = i; end
      if (ifc.ctl_stop) begin stops++; if (t_stop < 0) t_stop = i; end
      if (ifc.done) dones++;
      if (ifc.err) errs++;
      if (!ifc.busy) begin fin = 1'b1; break; end
      tick();
    end
    n_cmp++; if (fin !== 1'b1) begin n_bad++; $display("FAIL rerun_finish: got %0b want 1 (timeout)", fin); end
    n_cmp++; if (starts != 1 || stops != 1) begin n_bad++; $display("FAIL rerun_pulses: got %0d/%0d want 1/1", starts, stops); end
    n_cmp++; if (dones != 1 || errs != 0) begin n_bad++; $display("FAIL rerun_done_err: got %0d/%0d want 1/0", dones, errs); end
    n_cmp++; if (ifc.runs_done !== 8'd1) begin n_bad++; $display("FAIL rerun_runs: got %0d want 1", ifc.runs_done); end
    n_cmp++; if (t_stop - t_start != 3) begin n_bad++; $display("FAIL rerun_min_latency: got %0d want 3", t_stop - t_start); end
  endtask

  initial begin
    ifc.cmd_valid = 1'b0;
    ifc.cmd_count = '0;
    ifc.cmd_hold  = '0;
    ifc.abort     = 1'b0;
    test_reset();
    test_burst();
    test_zero_count();
    test_ack_timeout();
    test_clear_once();
    test_abort();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
